// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the serial program loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StLen,
      StData,
      StWrite,
      StCsum
   } state_e;

   typedef enum logic [1:0] {
      ErrNone    = 2'b00,
      ErrCsum    = 2'b01,
      ErrTimeout = 2'b10
   } err_e;

   localparam logic [7:0] SyncByteDefault = 8'hA5;

   function automatic int unsigned timeout_cycles(input int unsigned freq_hz,
                                                  input int unsigned ms);
      return freq_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte gap counter: expires after Cycles consecutive enabled, uncleared cycles.
module loader_timeout #(
   parameter int unsigned Cycles = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [31:0] Last = 32'(Cycles - 1);

   logic [31:0] cnt_q;

   assign expire = enable & ~clear & (cnt_q == Last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear || expire) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/uart_loader.sv
// Framed download parser: sync, LE address, LE length, payload, 8-bit sum; payload is
// written to memory as little-endian 32-bit words over a valid/ready bus.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned FREQ_HZ    = 25_000_000,
   parameter int unsigned TIMEOUT_MS = 100,
   parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        rx_done,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code
);

   localparam int unsigned TimeoutCycles = timeout_cycles(FREQ_HZ, TIMEOUT_MS);

   state_e      state_q;
   err_e        err_q;
   logic [31:0] addr_q;
   logic [31:0] count_q;
   logic [7:0]  sum_q;
   logic [1:0]  idx_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        valid_q;
   logic        done_q;
   logic        error_q;

   logic        accept;
   logic        counting;
   logic        expire;
   logic [7:0]  sum_next;
   logic [31:0] len_next;

   assign counting = state_q inside {StAddr, StLen, StData, StCsum};
   // No pop while a word is pending: the upstream FIFO absorbs the backpressure.
   assign accept   = rx_rdy & ~rst & (state_q != StWrite);
   assign sum_next = sum_q + rx_data;
   assign len_next = {rx_data, count_q[31:8]};

   loader_timeout #(
      .Cycles (TimeoutCycles)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept | ~counting),
      .enable (counting),
      .expire (expire)
   );

   assign rx_done   = accept;
   assign mem_valid = valid_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign error     = error_q;
   assign err_code  = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         err_q   <= ErrNone;
         addr_q  <= '0;
         count_q <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (expire) begin
            // Partially assembled word is discarded.
            state_q <= StIdle;
            error_q <= 1'b1;
            err_q   <= ErrTimeout;
            wstrb_q <= '0;
            lane_q  <= '0;
            idx_q   <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (accept && rx_data == SYNC_BYTE) begin
                     state_q <= StAddr;
                     sum_q   <= '0;
                     idx_q   <= '0;
                     err_q   <= ErrNone;
                  end
               end
               StAddr: begin
                  if (accept) begin
                     addr_q <= {rx_data, addr_q[31:8]};
                     sum_q  <= sum_next;
                     idx_q  <= idx_q + 2'd1;
                     if (idx_q == 2'd3) state_q <= StLen;
                  end
               end
               StLen: begin
                  if (accept) begin
                     count_q <= len_next;
                     sum_q   <= sum_next;
                     idx_q   <= idx_q + 2'd1;
                     if (idx_q == 2'd3) begin
                        lane_q  <= '0;
                        wstrb_q <= '0;
                        state_q <= (len_next == 32'd0) ? StCsum : StData;
                     end
                  end
               end
               StData: begin
                  if (accept) begin
                     wdata_q[{lane_q, 3'b000} +: 8] <= rx_data;
                     wstrb_q[lane_q] <= 1'b1;
                     count_q <= count_q - 32'd1;
                     sum_q   <= sum_next;
                     lane_q  <= lane_q + 2'd1;
                     if (lane_q == 2'd3 || count_q == 32'd1) begin
                        state_q <= StWrite;
                        valid_q <= 1'b1;
                     end
                  end
               end
               StWrite: begin
                  if (mem_ready) begin
                     valid_q <= 1'b0;
                     addr_q  <= addr_q + 32'd4;
                     wstrb_q <= '0;
                     lane_q  <= '0;
                     state_q <= (count_q != 32'd0) ? StData : StCsum;
                  end
               end
               StCsum: begin
                  if (accept) begin
                     state_q <= StIdle;
                     if (rx_data == sum_q) begin
                        done_q <= 1'b1;
                     end else begin
                        error_q <= 1'b1;
                        err_q   <= ErrCsum;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized bench for uart_loader: frames are built with known intent and the expected
// memory writes and outcome are derived from the frame contents alone.
module tb_uart_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        mem_ready = 1'b0;
   logic        rx_done, mem_valid, busy, done, error;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [1:0]  err_code;

   always #5 clk = ~clk;

   uart_loader #(
      .FREQ_HZ    (1_000_000),
      .TIMEOUT_MS (1),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_rdy    (rx_rdy),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_code  (err_code)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   logic [7:0] fifo[$];
   logic [7:0] pl[$];
   wr_t        exp_wr[$];
   wr_t        log_wr[$];
   int         exp_out[$];   // 0 done, 1 checksum error, 2 timeout

   bit hold_ready = 1'b0;
   int ready_pct = 100;
   bit pop_seen = 1'b0;
   int cyc = 0;
   int last_pop_cyc = 0;
   int last_out_cyc = 0;
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s: actual=%h required=none", name, act);
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
      return m;
   endfunction

   // Upstream FIFO model: pops the head one cycle after rx_done was seen.
   always @(posedge clk) begin
      #1;
      if (pop_seen && fifo.size() != 0) fifo.delete(0);
      pop_seen = 1'b0;
      rx_rdy = (fifo.size() != 0);
      rx_data = rx_rdy ? fifo[0] : 8'h00;
      mem_ready = !hold_ready && (int'($urandom_range(0, 99)) < ready_pct);
   end

   logic        pv, pr, pp;
   logic [31:0] pa, pd;
   logic [3:0]  ps;

   always @(negedge clk) begin : monitor
      wr_t e;
      wr_t g;
      int  o;
      cyc++;
      if (rst) begin
         pv = 1'b0;
         pp = 1'b0;
         pop_seen = 1'b0;
      end else begin
         if (mem_valid && rx_rdy) check("no_pop_in_write", rx_done, 0);
         if (pv && !pr) begin
            check("valid_held", mem_valid, 1);
            check("addr_held", mem_addr, pa);
            check("wdata_held", mem_wdata, pd);
            check("wstrb_held", mem_wstrb, ps);
         end
         if (mem_valid && !pv) check("valid_after_pop", pp, 1);
         if (mem_valid && mem_ready) begin
            if (exp_wr.size() == 0) begin
               fail_now("unexpected_write", mem_addr);
            end else begin
               e = exp_wr.pop_front();
               check("write_addr", mem_addr, e.a);
               check("write_strb", mem_wstrb, e.s);
               check("write_data", mem_wdata & lane_mask(e.s), e.d & lane_mask(e.s));
            end
            g.a = mem_addr;
            g.d = mem_wdata;
            g.s = mem_wstrb;
            log_wr.push_back(g);
         end
         if (done || error) begin
            last_out_cyc = cyc;
            if (exp_out.size() == 0) begin
               fail_now("unexpected_outcome", {30'd0, done, error});
            end else begin
               o = exp_out.pop_front();
               check("outcome_done", done, (o == 0));
               check("outcome_error", error, (o != 0));
               check("outcome_err_code", err_code, o);
               if (o != 2) check("result_after_pop", pp, 1);
            end
         end
         pv = mem_valid;
         pr = mem_ready;
         pa = mem_addr;
         pd = mem_wdata;
         ps = mem_wstrb;
         pp = rx_done;
         if (rx_done) last_pop_cyc = cyc;
         pop_seen = rx_done;
      end
   end

   // trunc < 0: whole frame; otherwise only the sync plus trunc following bytes are sent.
   task automatic send_frame(input logic [31:0] addr, input bit bad, input int trunc,
                             input int gap_max);
      logic [7:0]  b[$];
      logic [7:0]  sum;
      logic [31:0] len;
      int          n, k, nw, limit;
      wr_t         w;
      n = pl.size();
      len = 32'(n);
      b.push_back(8'hA5);
      for (int i = 0; i < 4; i++) b.push_back(addr[8*i +: 8]);
      for (int i = 0; i < 4; i++) b.push_back(len[8*i +: 8]);
      foreach (pl[i]) b.push_back(pl[i]);
      sum = 8'h00;
      for (int i = 1; i < b.size(); i++) sum = sum + b[i];
      b.push_back(bad ? sum + 8'($urandom_range(1, 255)) : sum);

      if (trunc < 0) k = n;
      else if (trunc - 8 < 0) k = 0;
      else if (trunc - 8 > n) k = n;
      else k = trunc - 8;
      nw = (k == n) ? (n + 3) / 4 : k / 4;
      for (int wi = 0; wi < nw; wi++) begin
         w.a = {addr[31:2], 2'b00} + 32'(4 * wi);
         w.d = '0;
         w.s = '0;
         for (int l = 0; l < 4; l++) begin
            if (4 * wi + l < k) begin
               w.d[8*l +: 8] = pl[4*wi + l];
               w.s[l] = 1'b1;
            end
         end
         exp_wr.push_back(w);
      end
      exp_out.push_back((trunc >= 0) ? 2 : (bad ? 1 : 0));

      limit = (trunc >= 0) ? trunc + 1 : b.size();
      for (int i = 0; i < limit; i++) begin
         fifo.push_back(b[i]);
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
   endtask

   task automatic wait_frame();
      int t = 0;
      while (exp_out.size() != 0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 4000) begin
         fail_now("frame_bound", 32'(exp_out.size()));
         exp_out.delete();
      end
      repeat (2) @(negedge clk);
      check("writes_drained", exp_wr.size(), 0);
      exp_wr.delete();
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a byte waiting upstream: nothing may be popped.
      fifo.push_back(8'hA5);
      repeat (3) @(negedge clk);
      check("rst_rx_done", rx_done, 0);
      check("rst_mem_valid", mem_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_code", err_code, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      fifo.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Two full words.
      pl = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
      log_wr.delete();
      send_frame(32'h0000_1000, 1'b0, -1, 0);
      wait_frame();
      check("t1_nwrites", log_wr.size(), 2);
      if (log_wr.size() == 2) begin
         check("t1_addr0", log_wr[0].a, 32'h0000_1000);
         check("t1_data0", log_wr[0].d, 32'h1413_1211);
         check("t1_strb0", log_wr[0].s, 4'hF);
         check("t1_addr1", log_wr[1].a, 32'h0000_1004);
         check("t1_data1", log_wr[1].d, 32'h1817_1615);
         check("t1_strb1", log_wr[1].s, 4'hF);
      end
      check("t1_err_code", err_code, 2'b00);

      // Partial last word.
      pl = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
      ready_pct = 50;
      log_wr.delete();
      send_frame(32'h0000_1000, 1'b0, -1, 2);
      wait_frame();
      check("t2_nwrites", log_wr.size(), 2);
      if (log_wr.size() == 2) begin
         check("t2_addr1", log_wr[1].a, 32'h0000_1004);
         check("t2_strb1", log_wr[1].s, 4'b0011);
         check("t2_data1_lo", {16'h0, log_wr[1].d[15:0]}, 32'h0000_1615);
      end

      // Empty payload, good then bad checksum.
      pl.delete();
      log_wr.delete();
      send_frame(32'h0000_1000, 1'b0, -1, 1);
      wait_frame();
      check("t3_nwrites", log_wr.size(), 0);
      check("t3_err_code", err_code, 2'b00);
      send_frame(32'h0000_1000, 1'b1, -1, 1);
      wait_frame();
      check("t4_err_code", err_code, 2'b01);

      // Long write stall with bytes queued: no pop, no timeout, nothing lost.
      hold_ready = 1'b1;
      ready_pct = 100;
      pl = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
      send_frame(32'h0000_2000, 1'b0, -1, 0);
      repeat (1200) @(negedge clk);
      check("bp_queued", fifo.size(), 5);
      check("bp_valid", mem_valid, 1);
      check("bp_busy", busy, 1);
      hold_ready = 1'b0;
      wait_frame();
      check("bp_err_code", err_code, 2'b00);

      // Junk before sync.
      fifo.push_back(8'h00);
      fifo.push_back(8'hFF);
      fifo.push_back(8'h5A);
      pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      log_wr.delete();
      send_frame(32'h0000_2100, 1'b0, -1, 1);
      wait_frame();
      check("junk_nwrites", log_wr.size(), 2);

      // Stall after two payload bytes.
      pl = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
      log_wr.delete();
      send_frame(32'h0000_3000, 1'b0, 10, 0);
      wait_frame();
      check("to_gap", 32'(last_out_cyc - last_pop_cyc), 1001);
      check("to_nwrites", log_wr.size(), 0);
      check("to_err_code", err_code, 2'b10);
      check("to_busy", busy, 0);

      // Reset in the middle of payload.
      send_frame(32'h0000_4000, 1'b0, 10, 0);
      repeat (30) @(negedge clk);
      check("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rx_done", rx_done, 0);
      check("mid_mem_valid", mem_valid, 0);
      check("mid_busy_rst", busy, 0);
      check("mid_done", done, 0);
      check("mid_error", error, 0);
      check("mid_err_code", err_code, 0);
      check("mid_mem_addr", mem_addr, 0);
      check("mid_mem_wdata", mem_wdata, 0);
      check("mid_mem_wstrb", mem_wstrb, 0);
      exp_out.delete();
      exp_wr.delete();
      fifo.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (1100) @(negedge clk);
      check("mid_idle_after", busy, 0);

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         int          n, trunc;
         logic [31:0] addr;
         logic [7:0]  j;
         bit          bad;
         n = int'($urandom_range(0, 20));
         pl.delete();
         for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
         addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : 32'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         trunc = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 8 + n)) : -1;
         ready_pct = int'($urandom_range(30, 100));
         if ($urandom_range(0, 3) == 0) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h00;
            fifo.push_back(j);
         end
         send_frame(addr, bad, trunc, 4);
         wait_frame();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
